// File: rtl/bin2bcd_scan.sv
// ============================================================================
//  Module      : bin2bcd_scan
//  Description : Serial shift-and-add-3 binary-to-BCD converter with a
//                multiplexed 7-segment digit scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_scan #(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   digits,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int          ACC_W   = 4 * DIGITS;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam int          PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int          IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [31:0] MAX_DEC = 32'(10 ** DIGITS - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]        state_q,   state_d;
    logic [BIN_W-1:0]  shreg_q,   shreg_d;
    logic [ACC_W-1:0]  acc_q,     acc_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              big_q,     big_d;
    logic              ovf_q,     ovf_d;
    logic              done_q,    done_d;
    logic [ACC_W-1:0]  disp_q,    disp_d;
    logic [PRE_W-1:0]  pre_q,     pre_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [3:0]        bcd_q,     bcd_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;

    logic [ACC_W-1:0]  acc_adj;
    logic [ACC_W-1:0]  acc_shift;
    logic [BIN_W-1:0]  sh_shift;
    logic              wrap;
    logic [3:0]        cur_digit;
    logic              upper_zero;

    // Nibble-local add-3; no carry crosses a digit boundary.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        assign acc_adj[4*g +: 4] = (acc_q[4*g +: 4] >= 4'd5) ? acc_q[4*g +: 4] + 4'd3
                                                             : acc_q[4*g +: 4];
    end

    assign acc_shift = {acc_adj[ACC_W-2:0], shreg_q[BIN_W-1]};
    assign sh_shift  = {shreg_q[BIN_W-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            big_q     <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            disp_q    <= '1;
            pre_q     <= '0;
            idx_q     <= '0;
            bcd_q     <= 4'hF;
            dig_sel_q <= DIGITS'(1);
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            big_q     <= big_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            disp_q    <= disp_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            bcd_q     <= bcd_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        big_d   = big_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        disp_d  = disp_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d = bin;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    big_d   = (32'(bin) > MAX_DEC);
                    ovf_d   = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            default: begin
                acc_d   = acc_shift;
                shreg_d = sh_shift;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    // Out-of-range values show as an all-blank display.
                    if (big_q) begin
                        ovf_d  = 1'b1;
                        disp_d = '1;
                    end else begin
                        disp_d = acc_shift;
                    end
                end
            end
        endcase
    end

    always_comb begin
        wrap  = (pre_q == PRE_W'(SCAN_DIV - 1));
        pre_d = wrap ? '0 : pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        cur_digit  = 4'h0;
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                cur_digit = disp_q[4*i +: 4];
            end
            if (IDX_W'(i) >= idx_q && disp_q[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end

        bcd_d     = (blank_lz && idx_q != '0 && upper_zero) ? 4'hF : cur_digit;
        dig_sel_d = DIGITS'(1) << idx_q;
    end

    always_comb begin
        busy    = (state_q == S_SHIFT);
        done    = done_q;
        ovf     = ovf_q;
        digits  = disp_q;
        bcd     = bcd_q;
        dig_sel = dig_sel_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_scan.sv
// ============================================================================
//  Module      : tb_bin2bcd_scan
//  Description : Self-checking bench for bin2bcd_scan against a decimal model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_scan;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        blank_lz = 1'b0;
    logic [13:0] bin      = '0;

    logic        busy, done, ovf;
    logic [15:0] digits;
    logic [3:0]  bcd;
    logic [3:0]  dig_sel;

    logic        busy_f, done_f, ovf_f;
    logic [15:0] digits_f;
    logic [3:0]  bcd_f;
    logic [3:0]  dig_sel_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin2bcd_scan #(.BIN_W(14), .DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .blank_lz(blank_lz),
        .busy(busy), .done(done), .ovf(ovf), .digits(digits), .bcd(bcd), .dig_sel(dig_sel)
    );

    bin2bcd_scan #(.BIN_W(14), .DIGITS(4), .SCAN_DIV(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .blank_lz(blank_lz),
        .busy(busy_f), .done(done_f), .ovf(ovf_f), .digits(digits_f), .bcd(bcd_f),
        .dig_sel(dig_sel_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_digits(input int v);
        logic [15:0] r;
        if (v > 9999) return 16'hFFFF;
        r = '0;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    function automatic logic [3:0] model_bcd(input int v, input int idx, input bit blank);
        int q;
        q = v / (10 ** idx);
        if (blank && idx > 0 && q == 0) return 4'hF;
        return 4'(q % 10);
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_digits"}, 32'(digits), 32'hFFFF);
        chk({tag, "_dig_sel"}, 32'(dig_sel), 32'h1);
        chk({tag, "_bcd"}, 32'(bcd), 32'hF);
    endtask

    task automatic convert(input int v, input bit inject);
        logic [15:0] prev;
        int cyc, busy_cnt, extra;
        bit held;
        prev = digits;
        @(negedge clk);
        bin   = 14'(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ovf_clear_at_start", 32'(ovf), 32'd0);
        chk("busy_rise", 32'(busy), 32'd1);
        cyc = 0; busy_cnt = 0; held = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (digits !== prev) held = 1'b0;
            start = inject && (cyc == 2 || cyc == 6);
            bin   = 14'($urandom);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_latency", 32'(cyc), 32'd14);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("busy_cycles", 32'(busy_cnt), 32'd14);
        chk("old_value_held", 32'(held), 32'd1);
        chk("digits", 32'(digits), 32'(model_digits(v)));
        chk("ovf", 32'(ovf), 32'(v > 9999));
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        if (inject) begin
            extra = 0;
            repeat (20) begin
                if (done === 1'b1 || busy === 1'b1) extra++;
                @(negedge clk);
            end
            chk("ignored_starts", 32'(extra), 32'd0);
            chk("digits_after_ignored", 32'(digits), 32'(model_digits(v)));
        end
    endtask

    task automatic scan_check(input int v, input bit blank);
        int idx, prev_idx, run;
        bit map_ok, hold_ok, order_ok, wrapped, seen_change;
        blank_lz = blank;
        repeat (3) @(negedge clk);
        map_ok = 1'b1; hold_ok = 1'b1; order_ok = 1'b1; wrapped = 1'b0; seen_change = 1'b0;
        prev_idx = -1; run = 0;
        for (int s = 0; s < 33; s++) begin
            idx = -1;
            for (int i = 0; i < 4; i++) if (dig_sel === 4'(1 << i)) idx = i;
            if (idx < 0 || bcd !== model_bcd(v, idx, blank)) map_ok = 1'b0;
            if (s > 0 && idx != prev_idx) begin
                if (seen_change && run != 4) hold_ok = 1'b0;
                if (idx != (prev_idx + 1) % 4) order_ok = 1'b0;
                if (prev_idx == 3 && idx == 0) wrapped = 1'b1;
                seen_change = 1'b1;
                run = 1;
            end else begin
                run++;
            end
            prev_idx = idx;
            @(negedge clk);
        end
        chk("scan_digit_map", 32'(map_ok), 32'd1);
        chk("scan_hold_4", 32'(hold_ok), 32'd1);
        chk("scan_order", 32'(order_ok), 32'd1);
        chk("scan_wrap", 32'(wrapped), 32'd1);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin : stimulus
        logic [3:0] prev_f;
        int v, bad;
        bit fast_ok;

        repeat (2) @(negedge clk);
        check_reset_state("reset_initial");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        convert(1234, 1'b0);
        convert(0, 1'b0);
        convert(9999, 1'b0);
        convert(10000, 1'b0);
        convert(16383, 1'b0);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        convert(5, 1'b0);

        convert(7, 1'b0);
        scan_check(7, 1'b1);
        scan_check(7, 1'b0);
        convert(0, 1'b0);
        scan_check(0, 1'b1);

        fast_ok = 1'b1;
        prev_f  = dig_sel_f;
        repeat (8) begin
            @(negedge clk);
            if (dig_sel_f !== {prev_f[2:0], prev_f[3]}) fast_ok = 1'b0;
            prev_f = dig_sel_f;
        end
        chk("scan_div1_every_cycle", 32'(fast_ok), 32'd1);

        convert(42, 1'b1);

        for (int n = 0; n < 12; n++) begin
            v = int'($urandom_range(0, 16383));
            convert(v, 1'b0);
            if (v <= 9999) scan_check(v, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        bin   = 14'd555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_mid_conv");
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("no_done_after_abort", 32'(bad), 32'd0);
        chk("digits_blank_after_abort", 32'(digits), 32'hFFFF);
        convert(321, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
